pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised elastic pipeline stage register, successor to the fixed MEM/WB flop bank. It carries a generic packed payload between two pipeline stages using a valid/ready handshake. A two-entry skid buffer lets an upstream stage see a registered ready while the downstream stage stalls, with no bubbles and no lost data. It supports synchronous flush and is instantiated between any pair of core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
W, 16, payload width in bits (packed fields, e.g. regwrite_dat, flags, regwrite, regwrite_adr, main_mem_dat).
RST_VAL, 0, payload value loaded on reset/flush and held while empty (W bits).
CNT_W, 16, width of the stall counter (used only with the optional feature).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous pipeline flush; discards all held entries
in_valid  input  1  upstream presents a payload
in_ready  output  1  stage can accept; registered (no combinational path from out_ready)
in_data  input  W  upstream payload
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts this cycle
out_data  output  W  payload to downstream; registered
stall_cnt  output  CNT_W  saturating stall-cycle count (only with PIPE_STAGE_STATS_EN)

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high. Reset has priority over flush, and flush has priority over handshakes.
- Storage: main register (drives out_data) and skid register. State is EMPTY, ONE (main full) or TWO (main and skid full).
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO), driven from a flop.
  - Accept when in_valid & in_ready. Deliver when out_valid & out_ready.
- Reset or flush, next cycle:
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - main and skid = RST_VAL.
  - An in_valid beat presented in the same cycle is dropped.
  - stall_cnt is cleared by reset only, not by flush.
- Transitions:
  - EMPTY: accept -> ONE, main <= in_data. No accept -> stay.
  - ONE:
    - accept & deliver -> ONE, main <= in_data.
    - accept & !deliver -> TWO, skid <= in_data, main unchanged.
    - !accept & deliver -> EMPTY, main <= RST_VAL.
    - otherwise hold.
  - TWO (in_ready = 0): deliver -> ONE, main <= skid, skid <= RST_VAL. Otherwise hold. in_valid is ignored.
- Latency and ordering:
  - Latency is 1 cycle from accept to out_valid when empty.
  - Sustained throughput is 1 beat/cycle while out_ready = 1.
  - Order is strictly FIFO; no duplication or loss.
- Payload stability: out_data must not change while out_valid = 1 and out_ready = 0. out_data equals RST_VAL whenever out_valid = 0.
- Upstream rule: in_data is sampled only on accept.
- Bubble rule: in_valid = 0 with out_ready = 1 drains one entry per cycle.
- Width: the payload is opaque. No arithmetic is performed on it; W may be any value >= 1.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cnt port exists.
  - Increments by 1 each cycle with out_valid = 1 and out_ready = 0.
  - Saturates at 2^CNT_W-1; does not wrap.
  - Reset to 0 by reset only.
- Undefined: stall_cnt port and its counter are absent; the rest of the behaviour is identical.

Test Plan:
- Reset with in_valid = 1, in_data = 16'hABCD -> next cycle out_valid = 0, out_data = 0, in_ready = 1; no beat delivered.
- Stream 0x0001..0x0008 on consecutive cycles, out_ready = 1 -> out_data 0x0001..0x0008 on consecutive cycles, starting 1 cycle after first accept; in_ready stays 1.
- Send 0x1111, then 0x2222 while out_ready = 0 -> state TWO, in_ready = 0, out_data holds 0x1111. Raise out_ready -> 0x1111 then 0x2222 delivered; in_ready returns to 1 one cycle after first delivery.
- Flush in state TWO with in_valid = 1, in_data = 0x3333 -> next cycle out_valid = 0, in_ready = 1; 0x3333 is never delivered.
- Randomised in_valid/out_ready (50%) for 1000 cycles, W = 37 -> output sequence equals accepted sequence; out_data stable during stalls.
- With PIPE_STAGE_STATS_EN, CNT_W = 4: hold a valid entry with out_ready = 0 for 20 cycles -> stall_cnt = 15 (saturated). Flush -> remains 15. Reset -> 0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Elastic pipeline stage register with a two-entry skid buffer.
//               Carries an opaque W-bit payload between two core stages over a
//               valid/ready handshake. in_ready is driven from a flop, so there
//               is no combinational path from out_ready back to in_ready. The
//               stage streams one beat per cycle without bubbles, keeps strict
//               FIFO order and supports a synchronous flush.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   W        payload width in bits (>= 1)
//   RST_VAL  payload value loaded on reset/flush and held while empty
//   CNT_W    stall counter width (statistics build only)
// Ports
//   clk        in   clock, all state updates on rising edge
//   reset      in   synchronous, active-high reset (priority over flush)
//   flush      in   synchronous flush, discards all held entries
//   in_valid   in   upstream presents a payload
//   in_ready   out  stage can accept (registered)
//   in_data    in   upstream payload, sampled only on accept
//   out_valid  out  out_data is valid
//   out_ready  in   downstream accepts this cycle
//   out_data   out  payload to downstream (registered)
//   stall_cnt  out  saturating count of cycles with out_valid & !out_ready
//                   (present only when PIPE_STAGE_STATS_EN is defined)
// Build option
//   PIPE_STAGE_STATS_EN  adds the stall_cnt port and its counter
// ============================================================================
module pipe_stage_skid #(
    parameter int unsigned         W       = 16,
    parameter logic [W-1:0]        RST_VAL = '0,
    parameter int unsigned         CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   main_q,  main_d;
    logic [W-1:0]   skid_q,  skid_d;
    logic           in_ready_q, in_ready_d;

    logic           w_accept;
    logic           w_deliver;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;

    assign w_accept  = in_valid  & in_ready_q;
    assign w_deliver = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= RST_VAL;
            skid_q     <= RST_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (w_accept && w_deliver) begin
                    main_d  = in_data;
                end else if (w_accept) begin
                    // Downstream stalled: park the new beat behind main.
                    state_d = ST_TWO;
                    skid_d  = in_data;
                end else if (w_deliver) begin
                    state_d = ST_EMPTY;
                    main_d  = RST_VAL;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so in_valid cannot be accepted.
                if (w_deliver) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                    skid_d  = RST_VAL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = RST_VAL;
                skid_d  = RST_VAL;
            end
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end

        // Registering the next-state decode keeps in_ready free of any
        // combinational dependency on out_ready.
        in_ready_d = (state_d != ST_TWO);
    end

`ifdef PIPE_STAGE_STATS_EN
    // ------------------------------------------------------------------------
    // Saturating stall counter; flush deliberately leaves it untouched.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid. A table of directed
//               vectors exercises a W=16 instance; a randomised stream checks
//               ordering and stall stability on a W=37 instance with a
//               non-zero RST_VAL; the statistics build also checks stall_cnt
//               saturation on a CNT_W=4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int unsigned   WB     = 37;
    localparam logic [WB-1:0] RV_B   = 37'h15_A5A5_A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- instance A: W=16, RST_VAL=0, CNT_W=4 ----------------
    logic        rst_a = 1'b1, fl_a = 1'b0, iv_a = 1'b0, or_a = 1'b0;
    logic [15:0] id_a  = '0;
    logic        ov_a, ir_a;
    logic [15:0] od_a;
`ifdef PIPE_STAGE_STATS_EN
    logic [3:0]  sc_a;
`endif

    pipe_stage_skid #(.W(16), .RST_VAL(16'h0000), .CNT_W(4)) dut_a (
        .clk       (clk),
        .reset     (rst_a),
        .flush     (fl_a),
        .in_valid  (iv_a),
        .in_ready  (ir_a),
        .in_data   (id_a),
        .out_valid (ov_a),
        .out_ready (or_a),
        .out_data  (od_a)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (sc_a)
`endif
    );

    // ---------------- instance B: W=37, non-zero RST_VAL ----------------
    logic          rst_b = 1'b1, fl_b = 1'b0, iv_b = 1'b0, or_b = 1'b0;
    logic [WB-1:0] id_b  = '0;
    logic          ov_b, ir_b;
    logic [WB-1:0] od_b;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]   sc_b;
`endif

    pipe_stage_skid #(.W(WB), .RST_VAL(RV_B), .CNT_W(16)) dut_b (
        .clk       (clk),
        .reset     (rst_b),
        .flush     (fl_b),
        .in_valid  (iv_b),
        .in_ready  (ir_b),
        .in_data   (id_b),
        .out_valid (ov_b),
        .out_ready (or_b),
        .out_data  (od_b)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (sc_b)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [15:0] id;
        logic        orr;
        logic        e_ov;
        logic        e_ir;
        logic [15:0] e_od;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rst, input logic fl, input logic iv, input logic [15:0] id,
                       input logic orr, input logic e_ov, input logic e_ir, input logic [15:0] e_od);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.orr = orr;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od;
        vt.push_back(v);
    endtask

    logic [WB-1:0] sb[$];
    logic [63:0]   rnd;
    logic          prev_stall;
    logic [WB-1:0] prev_od;
    logic [WB-1:0] exp_b;
    int            drain;

    initial begin
        // reset with a beat presented: beat dropped
        add(1, 0, 1, 16'hABCD, 0, 0, 1, 16'h0000);
        // idle EMPTY stays EMPTY
        add(0, 0, 0, 16'h7777, 1, 0, 1, 16'h0000);
        // stream 1..8 back-to-back with out_ready=1
        for (int i = 1; i <= 8; i++)
            add(0, 0, 1, 16'(i), 1, 1, 1, 16'(i));
        // bubble drains the last beat
        add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000);
        // fill skid: 1111 then 2222 while stalled
        add(0, 0, 1, 16'h1111, 0, 1, 1, 16'h1111);
        add(0, 0, 1, 16'h2222, 0, 1, 0, 16'h1111);
        // TWO ignores in_valid and holds
        add(0, 0, 1, 16'h5555, 0, 1, 0, 16'h1111);
        // release: 1111 delivered, 2222 moves to main, ready returns
        add(0, 0, 0, 16'h0000, 1, 1, 1, 16'h2222);
        add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000);
        // fill again then flush in TWO with a beat presented
        add(0, 0, 1, 16'h1111, 0, 1, 1, 16'h1111);
        add(0, 0, 1, 16'h2222, 0, 1, 0, 16'h1111);
        add(0, 1, 1, 16'h3333, 0, 0, 1, 16'h0000);
        add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000);
        // ONE hold, then reset+flush together
        add(0, 0, 1, 16'h4444, 0, 1, 1, 16'h4444);
        add(0, 0, 0, 16'h0000, 0, 1, 1, 16'h4444);
        add(1, 1, 1, 16'h9999, 1, 0, 1, 16'h0000);
        // accept after reset
        add(0, 0, 1, 16'h0BEE, 1, 1, 1, 16'h0BEE);
        add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000);

        foreach (vt[k]) begin
            @(negedge clk);
            rst_a = vt[k].rst; fl_a = vt[k].fl; iv_a = vt[k].iv;
            id_a  = vt[k].id;  or_a = vt[k].orr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", k), 64'(ov_a), 64'(vt[k].e_ov));
            check($sformatf("vec%0d in_ready",  k), 64'(ir_a), 64'(vt[k].e_ir));
            check($sformatf("vec%0d out_data",  k), 64'(od_a), 64'(vt[k].e_od));
        end

        // ---------------- randomised stream on W=37 ----------------
        @(negedge clk);
        rst_b = 1'b1; iv_b = 1'b0; or_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("b reset out_valid", 64'(ov_b), 64'(0));
        check("b reset out_data",  64'(od_b), 64'(RV_B));
        prev_stall = 1'b0;
        prev_od    = '0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            rnd  = {$urandom(), $urandom()};
            iv_b = rnd[63];
            id_b = rnd[WB-1:0];
            or_b = rnd[62];
            #1;
            if (prev_stall) begin
                check("b stall valid", 64'(ov_b), 64'(1));
                check("b stall data",  64'(od_b), 64'(prev_od));
            end
            if (!ov_b)
                check("b empty data", 64'(od_b), 64'(RV_B));
            if (ov_b && or_b) begin
                if (sb.size() == 0) begin
                    check("b spurious beat", 64'(1), 64'(0));
                end else begin
                    exp_b = sb.pop_front();
                    check("b order", 64'(od_b), 64'(exp_b));
                end
            end
            if (iv_b && ir_b)
                sb.push_back(id_b);
            prev_stall = ov_b && !or_b;
            prev_od    = od_b;
        end
        // drain with a bounded budget
        drain = 0;
        while (drain < 8) begin
            @(negedge clk);
            iv_b = 1'b0; or_b = 1'b1;
            #1;
            if (ov_b) begin
                if (sb.size() == 0) begin
                    check("b spurious beat", 64'(1), 64'(0));
                end else begin
                    exp_b = sb.pop_front();
                    check("b drain order", 64'(od_b), 64'(exp_b));
                end
            end
            drain++;
        end
        check("b leftover beats", 64'(sb.size()), 64'(0));
        check("b drained valid",  64'(ov_b), 64'(0));

`ifdef PIPE_STAGE_STATS_EN
        // ---------------- stall counter saturation ----------------
        @(negedge clk);
        rst_a = 1'b1; fl_a = 1'b0; iv_a = 1'b0; or_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        check("stall after reset", 64'(sc_a), 64'(0));
        iv_a = 1'b1; id_a = 16'hCAFE;
        @(negedge clk);
        iv_a = 1'b0;
        check("stall first", 64'(sc_a), 64'(0));
        for (int c = 0; c < 20; c++) @(negedge clk);
        check("stall saturated", 64'(sc_a), 64'(15));
        fl_a = 1'b1;
        @(negedge clk);
        fl_a = 1'b0;
        check("stall after flush", 64'(sc_a), 64'(15));
        check("flush out_valid",   64'(ov_a), 64'(0));
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("stall after reset2", 64'(sc_a), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
